// File: rtl/spi_slave_port_if.sv
// Pin-level SPI signals plus the on-chip byte streams and status of spi_slave_port.
// The slave modport is the port side; master is the SPI master / on-chip user side.
interface spi_slave_port_if;
    logic       SCLK;
    logic       SSn;
    logic       MOSI;
    logic       MISO;
    logic       MISO_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       overrun;
    logic       underrun;
    logic       clr_flags;
    logic       busy;

    modport slave (
        input  SCLK, SSn, MOSI, tx_data, tx_valid, rx_ready, clr_flags,
        output MISO, MISO_oe, tx_ready, rx_data, rx_valid, overrun, underrun, busy
    );

    modport master (
        output SCLK, SSn, MOSI, tx_data, tx_valid, rx_ready, clr_flags,
        input  MISO, MISO_oe, tx_ready, rx_data, rx_valid, overrun, underrun, busy
    );
endinterface

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder, 8-bit MSB-first frames, fully in the HCLK domain.
// SCLK/SSn/MOSI are oversampled; edges come from the last sync stage vs one delay flop.
module spi_slave_port #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEFAULT_TX  = 8'hFF
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    spi_slave_port_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sclk_sync, ssn_sync, mosi_sync;
    logic                   sclk_d, ssn_d;
    logic                   sclk_s, ssn_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ssn_fall;
    logic [2:0]             bitcnt;
    logic [7:0]             tx_shift, rx_shift, rx_byte, rx_data;
    logic                   rx_valid, overrun, underrun;
    logic                   load, deselect, rx_bit, tx_bit, byte_done, drop;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sclk_sync <= '0;
            ssn_sync  <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ssn_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], bus.SSn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ssn_d     <= ssn_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ssn_s     = ssn_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ssn_fall  = ~ssn_s & ssn_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Deselect outranks a coincident SCLK edge, so a master that drops SCLK and
    // raises SSn together does not trigger a reload (and a lost tx handshake).
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        deselect  = 1'b0;
        case (state)
            IDLE: begin
                if (ssn_fall) begin
                    state_nxt = ACTIVE;
                    load      = 1'b1;
                end
            end
            ACTIVE: begin
                if (ssn_s) begin
                    state_nxt = IDLE;
                    deselect  = 1'b1;
                end else if (sclk_fall && bitcnt == 3'd0) begin
                    load = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_bit    = (state == ACTIVE) && !ssn_s && sclk_rise;
    assign tx_bit    = (state == ACTIVE) && !ssn_s && sclk_fall && (bitcnt != 3'd0);
    assign rx_byte   = {rx_shift[6:0], mosi_s};
    assign byte_done = rx_bit && (bitcnt == 3'd7);
    assign drop      = byte_done && rx_valid && !bus.rx_ready;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tx_shift <= 8'h00;
        end else if (load) begin
            tx_shift <= bus.tx_valid ? bus.tx_data : DEFAULT_TX;
        end else if (tx_bit) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bitcnt   <= 3'd0;
            rx_shift <= 8'h00;
        end else if (deselect || (state == IDLE && ssn_fall)) begin
            bitcnt   <= 3'd0;
            rx_shift <= 8'h00;
        end else if (rx_bit) begin
            bitcnt   <= bitcnt + 3'd1;
            rx_shift <= rx_byte;
        end
    end

    // A byte completing while the consumer takes the old one is accepted in place.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (byte_done && !drop) begin
            rx_data  <= rx_byte;
            rx_valid <= 1'b1;
        end else if (rx_valid && bus.rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (drop)               overrun <= 1'b1;
            else if (bus.clr_flags) overrun <= 1'b0;
            if (load && !bus.tx_valid) underrun <= 1'b1;
            else if (bus.clr_flags)    underrun <= 1'b0;
        end
    end

    assign bus.MISO     = tx_shift[7];
    assign bus.MISO_oe  = (state == ACTIVE);
    assign bus.busy     = (state == ACTIVE);
    assign bus.tx_ready = load;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.overrun  = overrun;
    assign bus.underrun = underrun;
endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: a bit-banged SPI master against queue-based expectations
// (tx queue order or DEFAULT_TX per byte, rx stream equals MOSI bytes).
module tb_spi_slave_port;
    localparam int SS   = 2;
    localparam int HALF = 5;

    logic HCLK = 1'b0;
    logic HRESETn;
    spi_slave_port_if bus ();

    spi_slave_port #(.SYNC_STAGES(SS), .DEFAULT_TX(8'hFF)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         tx_strobes;
    bit         tx_pend;
    logic [7:0] tx_q[$];
    logic [7:0] rx_got[$];
    logic [7:0] txn_mosi[$];
    logic [7:0] txn_miso[$];

    // On-chip TX producer: presents the queue head, pops after a completed handshake.
    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        tx_pend      = 1'b0;
        tx_strobes   = 0;
        forever begin
            @(posedge HCLK); #1;
            if (tx_pend && tx_q.size() > 0) void'(tx_q.pop_front());
            bus.tx_valid = (tx_q.size() > 0);
            bus.tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
            tx_pend      = bus.tx_ready && bus.tx_valid;
            if (bus.tx_ready) tx_strobes++;
        end
    end

    // On-chip RX consumer: records every accepted byte.
    initial begin
        forever begin
            @(negedge HCLK); #1;
            if (HRESETn && bus.rx_valid && bus.rx_ready) rx_got.push_back(bus.rx_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic pulse_clr();
        @(negedge HCLK); bus.clr_flags = 1'b1;
        @(negedge HCLK); bus.clr_flags = 1'b0;
    endtask

    task automatic spi_select();
        @(negedge HCLK);
        bus.SSn = 1'b0;
        wait_cyc(HALF);
    endtask

    // Shift nbits of b MSB first; MISO sampled just before each rising edge.
    task automatic spi_bits(input logic [7:0] b, input int nbits, input bit clr_last,
                            output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = b[7-i];
            wait_cyc(HALF);
            got = {got[6:0], bus.MISO};
            bus.SCLK = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge HCLK);
                bus.clr_flags = clr_last && (i == nbits - 1) && (k == SS);
            end
            bus.SCLK = 1'b0;
        end
    endtask

    // Full transaction; SSn rises together with the final SCLK fall.
    task automatic spi_txn(input int n, input bit clr_last);
        logic [7:0] m;
        txn_miso.delete();
        tx_strobes = 0;
        spi_select();
        for (int j = 0; j < n; j++) begin
            spi_bits(txn_mosi[j], 8, clr_last && (j == n - 1), m);
            txn_miso.push_back(m);
        end
        bus.SSn = 1'b1;
        wait_cyc(3 * HALF);
    endtask

    task automatic test_reset();
        HRESETn       = 1'b0;
        bus.SCLK      = 1'b0;
        bus.SSn       = 1'b1;
        bus.MOSI      = 1'b0;
        bus.rx_ready  = 1'b0;
        bus.clr_flags = 1'b0;
        wait_cyc(3);
        n_checks++; if (bus.MISO !== 1'b0)     begin n_fail++; $display("FAIL reset_miso: got %b want 0", bus.MISO); end
        n_checks++; if (bus.MISO_oe !== 1'b0)  begin n_fail++; $display("FAIL reset_oe: got %b want 0", bus.MISO_oe); end
        n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
        n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        n_checks++; if ({bus.overrun, bus.underrun} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {bus.overrun, bus.underrun}); end
        @(negedge HCLK); HRESETn = 1'b1;
        wait_cyc(4);
        n_checks++; if ({bus.busy, bus.tx_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: busy/tx_ready got %b want 00", {bus.busy, bus.tx_ready}); end
    endtask

    task automatic test_single();
        tx_q = '{8'hA5};
        bus.rx_ready = 1'b0;
        rx_got.delete();
        wait_cyc(3);
        txn_mosi = '{8'h3C};
        spi_txn(1, 1'b0);
        n_checks++; if (txn_miso[0] !== 8'hA5) begin n_fail++; $display("FAIL single_miso: got %h want a5", txn_miso[0]); end
        n_checks++; if (bus.rx_data !== 8'h3C) begin n_fail++; $display("FAIL single_rx_data: got %h want 3c", bus.rx_data); end
        n_checks++; if (bus.rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_rx_valid: got %b want 1", bus.rx_valid); end
        n_checks++; if (tx_strobes != 1)       begin n_fail++; $display("FAIL single_strobes: got %0d want 1", tx_strobes); end
        n_checks++; if ({bus.overrun, bus.underrun} !== 2'b00) begin n_fail++; $display("FAIL single_flags: got %b want 00", {bus.overrun, bus.underrun}); end
        @(negedge HCLK); bus.rx_ready = 1'b1;
        wait_cyc(3);
        n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: rx_valid got %b want 0", bus.rx_valid); end
        n_checks++; if (rx_got.size() != 1 || rx_got[0] !== 8'h3C) begin n_fail++; $display("FAIL single_consumed: got %0d bytes want 1 byte 3c", rx_got.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_rx[3] = '{8'h01, 8'h02, 8'h03};
        logic [7:0] exp_tx[3] = '{8'h10, 8'h20, 8'h30};
        tx_q = '{8'h10, 8'h20, 8'h30};
        rx_got.delete();
        bus.rx_ready = 1'b1;
        wait_cyc(3);
        txn_mosi = '{8'h01, 8'h02, 8'h03};
        spi_txn(3, 1'b0);
        n_checks++; if (rx_got.size() != 3) begin n_fail++; $display("FAIL b2b_rx_count: got %0d want 3", rx_got.size()); end
        for (int j = 0; j < 3; j++) begin
            n_checks++; if (j >= rx_got.size() || rx_got[j] !== exp_rx[j]) begin n_fail++; $display("FAIL b2b_rx[%0d]: got %h want %h", j, (j < rx_got.size()) ? rx_got[j] : 8'hxx, exp_rx[j]); end
            n_checks++; if (txn_miso[j] !== exp_tx[j]) begin n_fail++; $display("FAIL b2b_miso[%0d]: got %h want %h", j, txn_miso[j], exp_tx[j]); end
        end
        n_checks++; if (tx_strobes != 3)         begin n_fail++; $display("FAIL b2b_strobes: got %0d want 3", tx_strobes); end
        n_checks++; if (bus.underrun !== 1'b0)   begin n_fail++; $display("FAIL b2b_underrun: got %b want 0", bus.underrun); end
    endtask

    task automatic test_underrun();
        tx_q.delete();
        wait_cyc(3);
        txn_mosi = '{8'h5A};
        spi_txn(1, 1'b0);
        n_checks++; if (txn_miso[0] !== 8'hFF) begin n_fail++; $display("FAIL underrun_miso: got %h want ff", txn_miso[0]); end
        n_checks++; if (bus.underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b want 1", bus.underrun); end
        wait_cyc(10);
        n_checks++; if (bus.underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b want 1", bus.underrun); end
        pulse_clr();
        wait_cyc(1);
        n_checks++; if (bus.underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear: got %b want 0", bus.underrun); end
    endtask

    task automatic test_overrun();
        tx_q = '{8'h11, 8'h22};
        bus.rx_ready = 1'b0;
        rx_got.delete();
        wait_cyc(3);
        txn_mosi = '{8'h55, 8'hAA};
        spi_txn(2, 1'b1);
        n_checks++; if (bus.rx_data !== 8'h55) begin n_fail++; $display("FAIL overrun_rx_data: got %h want 55", bus.rx_data); end
        n_checks++; if (bus.overrun !== 1'b1)  begin n_fail++; $display("FAIL overrun_set_wins: got %b want 1", bus.overrun); end
        @(negedge HCLK); bus.rx_ready = 1'b1;
        wait_cyc(3);
        n_checks++; if (rx_got.size() != 1 || rx_got[0] !== 8'h55) begin n_fail++; $display("FAIL overrun_drain: got %0d bytes want 1 byte 55", rx_got.size()); end
        pulse_clr();
        wait_cyc(1);
        n_checks++; if (bus.overrun !== 1'b0)  begin n_fail++; $display("FAIL overrun_clear: got %b want 0", bus.overrun); end
    endtask

    task automatic test_abort();
        logic [7:0] m;
        tx_q = '{8'h77};
        rx_got.delete();
        bus.rx_ready = 1'b1;
        wait_cyc(3);
        spi_select();
        spi_bits(8'hF0, 4, 1'b0, m);
        n_checks++; if ({bus.busy, bus.MISO_oe} !== 2'b11) begin n_fail++; $display("FAIL abort_active: busy/oe got %b want 11", {bus.busy, bus.MISO_oe}); end
        n_checks++; if (m !== 8'h07) begin n_fail++; $display("FAIL abort_partial_miso: got %h want 07", m); end
        bus.SSn = 1'b1;
        wait_cyc(SS + 2);
        n_checks++; if ({bus.busy, bus.MISO_oe} !== 2'b00) begin n_fail++; $display("FAIL abort_release: busy/oe got %b want 00", {bus.busy, bus.MISO_oe}); end
        n_checks++; if (bus.rx_valid !== 1'b0 || rx_got.size() != 0) begin n_fail++; $display("FAIL abort_no_rx: rx_valid %b bytes %0d want 0 0", bus.rx_valid, rx_got.size()); end
        wait_cyc(2 * HALF);
        tx_q = '{8'h9C};
        wait_cyc(3);
        txn_mosi = '{8'h81};
        spi_txn(1, 1'b0);
        n_checks++; if (rx_got.size() != 1 || rx_got[0] !== 8'h81) begin n_fail++; $display("FAIL abort_next_rx: got %0d bytes want 1 byte 81", rx_got.size()); end
        n_checks++; if (txn_miso[0] !== 8'h9C) begin n_fail++; $display("FAIL abort_next_miso: got %h want 9c", txn_miso[0]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        tx_q = '{8'hFF};
        bus.rx_ready = 1'b0;
        wait_cyc(3);
        spi_select();
        spi_bits(8'hC3, 5, 1'b0, m);
        HRESETn = 1'b0;
        #1;
        n_checks++; if ({bus.MISO, bus.MISO_oe, bus.busy, bus.tx_ready} !== 4'b0000) begin n_fail++; $display("FAIL midreset_ctrl: miso/oe/busy/tx_ready got %b want 0000", {bus.MISO, bus.MISO_oe, bus.busy, bus.tx_ready}); end
        n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL midreset_rx_data: got %h want 00", bus.rx_data); end
        n_checks++; if ({bus.rx_valid, bus.overrun, bus.underrun} !== 3'b000) begin n_fail++; $display("FAIL midreset_status: got %b want 000", {bus.rx_valid, bus.overrun, bus.underrun}); end
        @(negedge HCLK); bus.SSn = 1'b1; bus.MOSI = 1'b0;
        wait_cyc(3);
        HRESETn = 1'b1;
        rx_got.delete();
        bus.rx_ready = 1'b1;
        tx_q = '{8'h3E};
        wait_cyc(4);
        txn_mosi = '{8'hC3};
        spi_txn(1, 1'b0);
        n_checks++; if (rx_got.size() != 1 || rx_got[0] !== 8'hC3) begin n_fail++; $display("FAIL midreset_fresh_rx: got %0d bytes want 1 byte c3", rx_got.size()); end
        n_checks++; if (txn_miso[0] !== 8'h3E) begin n_fail++; $display("FAIL midreset_fresh_miso: got %h want 3e", txn_miso[0]); end
    endtask

    // Random frames: k of n bytes have TX data queued, the rest must come out as DEFAULT_TX.
    task automatic test_random();
        logic [7:0] exp_tx[$];
        int n, k;
        bus.rx_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 4);
            k = $urandom_range(0, n);
            exp_tx.delete();
            txn_mosi.delete();
            for (int j = 0; j < n; j++) begin
                txn_mosi.push_back(8'($urandom));
                exp_tx.push_back(j < k ? 8'($urandom) : 8'hFF);
            end
            pulse_clr();
            rx_got.delete();
            tx_q.delete();
            for (int j = 0; j < k; j++) tx_q.push_back(exp_tx[j]);
            wait_cyc(3);
            spi_txn(n, 1'b0);
            n_checks++; if (rx_got.size() != n) begin n_fail++; $display("FAIL rand%0d_rx_count: got %0d want %0d", t, rx_got.size(), n); end
            for (int j = 0; j < n; j++) begin
                n_checks++; if (j >= rx_got.size() || rx_got[j] !== txn_mosi[j]) begin n_fail++; $display("FAIL rand%0d_rx[%0d]: got %h want %h", t, j, (j < rx_got.size()) ? rx_got[j] : 8'hxx, txn_mosi[j]); end
                n_checks++; if (txn_miso[j] !== exp_tx[j]) begin n_fail++; $display("FAIL rand%0d_miso[%0d]: got %h want %h", t, j, txn_miso[j], exp_tx[j]); end
            end
            n_checks++; if (tx_strobes != n) begin n_fail++; $display("FAIL rand%0d_strobes: got %0d want %0d", t, tx_strobes, n); end
            n_checks++; if (bus.underrun !== (k < n)) begin n_fail++; $display("FAIL rand%0d_underrun: got %b want %b", t, bus.underrun, (k < n)); end
            n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rand%0d_overrun: got %b want 0", t, bus.overrun); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI responder (mode 0, CPOL=0/CPHA=0, MSB first, 8-bit frames) for the SoC SPI master peripherals.
- Lets an external SPI master, or a second SoC's SPI master, exchange bytes with on-chip logic over valid/ready byte streams.
- Runs entirely in the HCLK domain. SCLK, SSn and MOSI are oversampled through synchronizers; nothing is clocked by SCLK.

Parameters:
SYNC_STAGES, 2, flop stages on SCLK/SSn/MOSI synchronizers (min 2)
DEFAULT_TX, 8'hFF, byte shifted out on MISO when no TX byte is available (underrun)

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
SCLK  in  1  SPI clock from master
SSn  in  1  slave select, active low
MOSI  in  1  master-out data
MISO  out  1  slave-out data
MISO_oe  out  1  MISO output enable, high while selected
tx_data  in  8  next byte to transmit
tx_valid  in  1  tx_data valid; hold tx_valid/tx_data stable until handshake
tx_ready  out  1  one-cycle strobe; transfer occurs when tx_valid & tx_ready
rx_data  out  8  last received byte
rx_valid  out  1  rx_data holds an unread byte
rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
overrun  out  1  sticky: a received byte was dropped
underrun  out  1  sticky: DEFAULT_TX was sent for lack of tx_valid
clr_flags  in  1  synchronous clear of overrun/underrun
busy  out  1  high while selected (state ACTIVE)

Behaviour:

Reset values:
- Async reset (HRESETn low) clears all state immediately: MISO=0, MISO_oe=0, tx_ready=0, rx_data=0, rx_valid=0, overrun=0, underrun=0, busy=0.
- Bit counter and shifters reset to 0; synchronizer flops reset to SCLK=0, SSn=1, MOSI=0.

Synchronization and timing:
- SCLK, SSn and MOSI each pass through SYNC_STAGES flops.
- Edges are detected by comparing the last synchronized stage with one extra delay flop.
- Supported SCLK: f_SCLK <= f_HCLK/8, and SCLK high/low time >= 4 HCLK periods.

State machine:
- IDLE: entered on SSn high (synced). busy=0, MISO_oe=0.
- IDLE -> ACTIVE on the synced SSn falling edge. In that same cycle:
  - load TX shifter with tx_data if tx_valid, else DEFAULT_TX and set underrun;
  - assert tx_ready for 1 cycle;
  - bitcnt=0, MISO_oe=1, busy=1.
- MISO always equals TX shifter bit 7.
- ACTIVE, SCLK rising edge:
  - rx_shift <= {rx_shift[6:0], MOSI_sync}; bitcnt <= bitcnt+1 (3-bit, wraps 7->0).
  - On the wrap (8th bit), byte complete:
    - if rx_valid is 1 and rx_ready is 0 in that cycle: byte dropped, rx_data unchanged, overrun set;
    - else rx_data <= completed byte, rx_valid <= 1.
- ACTIVE, SCLK falling edge:
  - if bitcnt != 0: TX shifter shifts left, filling with 0;
  - if bitcnt == 0 (byte boundary): reload the TX shifter exactly as on select, including tx_ready strobe and underrun rule.
- ACTIVE -> IDLE on the synced SSn rising edge, at any bit position:
  - a partial RX byte is discarded and bitcnt=0;
  - a TX byte already handshaken is lost;
  - MISO_oe=0 in the same cycle.
- SCLK edges while in IDLE are ignored.

RX handshake and flags:
- rx_valid clears in the cycle after rx_valid & rx_ready.
- If a byte completes in the same cycle as rx_ready: accept the new byte, rx_valid stays 1, no overrun.
- Flags: clr_flags clears overrun/underrun next cycle. If a set and a clear occur in the same cycle, set wins.
- tx_ready is never asserted outside the two load points (select, byte boundary).

Test Plan:
- Single byte: tx_valid=1, tx_data=8'hA5; master selects and sends 8'h3C -> MISO bit sequence 1,0,1,0,0,1,0,1; rx_data=8'h3C with rx_valid=1; one tx_ready strobe at select; overrun=underrun=0.
- Back-to-back: 3 bytes 8'h01,8'h02,8'h03 under one SSn low, consumer holds rx_ready=1 -> three rx_valid pulses with matching data; master receives the TX queue 8'h10,8'h20,8'h30; exactly 3 tx_ready strobes.
- Underrun: tx_valid=0 at select -> master reads 8'hFF; underrun=1 until clr_flags pulse, then 0.
- Overrun: rx_ready=0, two bytes 8'h55,8'hAA sent -> rx_data stays 8'h55 and overrun=1. Assert clr_flags in the same cycle the second byte completes -> overrun still 1.
- Abort: SSn deasserted after 4 SCLK rising edges of 8'hF0 -> no rx_valid; MISO_oe=0 and busy=0 within SYNC_STAGES+2 cycles. Next full transfer of 8'h81 -> rx_data=8'h81.
- Reset mid-byte: HRESETn low after 5 bits -> all outputs at reset values asynchronously. After release, a fresh transfer of 8'hC3 -> rx_data=8'hC3.
